// File: rtl/rr_grant_if.sv
// rr_grant_if: request/grant bundle between the requesters and rr_grant_scheduler.
// master = requester side (drives en/req/done), slave = arbiter side.
interface rr_grant_if #(
  parameter int N    = 8,
  parameter int IDXW = 3
);
  logic            en;
  logic [N-1:0]    req;
  logic [N-1:0]    done;
  logic [N-1:0]    gnt;
  logic [IDXW-1:0] gnt_idx;
  logic            gnt_valid;
  logic            timeout;

  modport master (
    output en, req, done,
    input  gnt, gnt_idx, gnt_valid, timeout
  );

  modport slave (
    input  en, req, done,
    output gnt, gnt_idx, gnt_valid, timeout
  );
endinterface

// File: rtl/rr_grant_scheduler.sv
// rr_grant_scheduler: round-robin arbiter for a shared one-hot select resource.
// Grants are registered (one-hot plus binary index, always consistent), held
// until the owner signals done or drops its request, and followed by at least
// one idle turnaround cycle. Optional hold limit: define RR_GRANT_TIMEOUT_EN to
// force-release a grant after MAX_HOLD cycles and pulse timeout.
module rr_grant_scheduler #(
  parameter int N        = 8,
  parameter int IDXW     = 3,
  parameter int MAX_HOLD = 16
) (
  input  logic          clk,
  input  logic          rst,
  rr_grant_if.slave     bus
);

  if (N < 2 || N > 8 || (N & (N - 1)) != 0) begin : g_bad_n
    $error("rr_grant_scheduler: N must be a power of 2 in 2..8");
  end
  if ((1 << IDXW) != N) begin : g_bad_idxw
    $error("rr_grant_scheduler: IDXW must equal log2(N)");
  end
  if (MAX_HOLD < 2) begin : g_bad_hold
    $error("rr_grant_scheduler: MAX_HOLD must be at least 2");
  end

  typedef enum logic {S_IDLE, S_GRANT} state_e;

  state_e          state_q, state_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [IDXW-1:0] idx_q, idx_d;

  logic            found;
  logic [IDXW-1:0] sel;
  logic [IDXW-1:0] cand;
  logic            rel;

`ifdef RR_GRANT_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD);
  logic [HW-1:0] hold_q, hold_d;
  logic          timeout_q, timeout_d;
  logic          force_rel;
`endif

  // Next-state: rotating priority scan, grant hold and release decisions.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    found   = 1'b0;
    sel     = '0;
    cand    = '0;
    rel     = 1'b0;
`ifdef RR_GRANT_TIMEOUT_EN
    hold_d    = hold_q;
    timeout_d = 1'b0;
    force_rel = 1'b0;
`endif

    // Scan ptr, ptr+1, ... with natural wrap of the IDXW-bit sum (N = 2**IDXW).
    for (int i = 0; i < N; i++) begin
      cand = ptr_q + IDXW'(i);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (bus.en && found) begin
          state_d    = S_GRANT;
          gnt_d      = '0;
          gnt_d[sel] = 1'b1;
          idx_d      = sel;
          ptr_d      = sel + IDXW'(1);
`ifdef RR_GRANT_TIMEOUT_EN
          hold_d     = '0;
`endif
        end
      end
      S_GRANT: begin
        // Only the owner's done/req matter; done with req low is one release.
        rel = bus.done[idx_q] || !bus.req[idx_q];
`ifdef RR_GRANT_TIMEOUT_EN
        hold_d    = hold_q + HW'(1);
        force_rel = (hold_q == HW'(MAX_HOLD - 1));
        timeout_d = force_rel && !rel;
        if (rel || force_rel) begin
`else
        if (rel) begin
`endif
          state_d = S_IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State, pointer and grant registers; reset drops any active grant silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
    end
  end

`ifdef RR_GRANT_TIMEOUT_EN
  // Hold counter and one-cycle timeout pulse aligned with the forced release.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = idx_q;
  assign bus.gnt_valid = (state_q == S_GRANT);

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// tb_rr_grant_scheduler: directed bench for rr_grant_scheduler (N=8, MAX_HOLD=16).
// Covers reset, round-robin order, wrap-around, release by drop, enable gating
// and the hold-limit behaviour with RR_GRANT_TIMEOUT_EN defined or not.
module tb_rr_grant_scheduler;

  localparam int N    = 8;
  localparam int IDXW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks   = 0;
  int failures = 0;

  rr_grant_if #(.N(N), .IDXW(IDXW)) bus ();

  rr_grant_scheduler #(.N(N), .IDXW(IDXW), .MAX_HOLD(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_grant(input string tag, input int idx);
    logic [31:0] oh;
    oh = 32'h1 << idx;
    check_eq({tag, "_valid"}, 32'(bus.gnt_valid), 32'h1);
    check_eq({tag, "_gnt"},   32'(bus.gnt), oh);
    check_eq({tag, "_idx"},   32'(bus.gnt_idx), 32'(idx));
  endtask

  task automatic expect_idle(input string tag, input int last_idx);
    check_eq({tag, "_valid"}, 32'(bus.gnt_valid), 32'h0);
    check_eq({tag, "_gnt"},   32'(bus.gnt), 32'h0);
    check_eq({tag, "_idx"},   32'(bus.gnt_idx), 32'(last_idx));
    check_eq({tag, "_to"},    32'(bus.timeout), 32'h0);
  endtask

  int held;
  logic to_seen;

  initial begin
    bus.en   = 1'b0;
    bus.req  = '0;
    bus.done = '0;
    rst      = 1'b1;
    tick(); tick();
    expect_idle("reset", 0);
    rst = 1'b0;

    // Reset in the middle of a grant.
    bus.en  = 1'b1;
    bus.req = 8'h04;
    tick();
    expect_grant("rst_g", 2);
    tick(); tick();
    expect_grant("rst_hold", 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_idle("rst_mid", 0);
    // ptr back at 0: with req 0 and 2 pending, 0 must win.
    bus.req = 8'h05;
    tick();
    expect_grant("rst_ptr", 0);
    bus.req = 8'h00;
    tick();
    expect_idle("rst_rel", 0);

    // Round-robin with all requesting, done pulsed one cycle after each grant.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req = 8'hFF;
    for (int k = 0; k <= N; k++) begin
      tick();
      expect_grant("rr", k % N);
      bus.done = 8'h1 << (k % N);
      tick();
      bus.done = '0;
      expect_idle("rr_gap", k % N);
    end
    bus.req = 8'h00;
    tick();

    // Wrap-around: grant 6 leaves ptr=7, then req {0,2} -> 0 then 2.
    bus.req = 8'h40;
    tick();
    expect_grant("wrap_6", 6);
    bus.req = 8'h00;
    tick();
    expect_idle("wrap_rel6", 6);
    bus.req = 8'h05;
    tick();
    expect_grant("wrap_0", 0);
    bus.done = 8'h01;
    tick();
    bus.done = '0;
    expect_idle("wrap_rel0", 0);
    tick();
    expect_grant("wrap_2", 2);
    bus.req = 8'h00;
    tick();
    expect_idle("wrap_rel2", 2);

    // Release by dropping req; done of a non-owner is ignored.
    bus.req = 8'h08;
    tick();
    expect_grant("drop_g", 3);
    bus.done = 8'h20;
    tick();
    expect_grant("drop_d5a", 3);
    tick();
    expect_grant("drop_d5b", 3);
    bus.done = '0;
    bus.req  = 8'h00;
    tick();
    expect_idle("drop_rel", 3);

    // Enable gating.
    bus.en  = 1'b0;
    bus.req = 8'h10;
    for (int c = 0; c < 5; c++) begin
      tick();
      check_eq("en_block", 32'(bus.gnt), 32'h0);
    end
    bus.en = 1'b1;
    tick();
    expect_grant("en_g", 4);
    bus.en = 1'b0;
    tick(); tick(); tick();
    expect_grant("en_hold", 4);
    bus.req = 8'h00;
    tick();
    expect_idle("en_rel", 4);
    bus.req = 8'h10;
    tick(); tick();
    expect_idle("en_next_blk", 4);

    // Hold limit: req[1] held with no done (ptr=5, scan wraps to 1).
    bus.req = 8'h02;
    bus.en  = 1'b1;
    tick();
    expect_grant("to_g", 1);
    held    = 0;
    to_seen = 1'b0;
    for (int c = 0; c < 150; c++) begin
      if (!bus.gnt_valid) break;
      held++;
      to_seen = to_seen | bus.timeout;
      tick();
    end
`ifdef RR_GRANT_TIMEOUT_EN
    check_eq("to_held", 32'(held), 32'd16);
    check_eq("to_early", 32'(to_seen), 32'h0);
    check_eq("to_pulse", 32'(bus.timeout), 32'h1);
    check_eq("to_drop", 32'(bus.gnt), 32'h0);
    tick();
    check_eq("to_pulse_end", 32'(bus.timeout), 32'h0);
`else
    check_eq("hold_forever", 32'(held), 32'd150);
    check_eq("no_timeout", 32'(to_seen | bus.timeout), 32'h0);
    expect_grant("hold_still", 1);
`endif
    bus.req = 8'h00;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_grant_scheduler.md
Name: rr_grant_scheduler

Overview:
- Round-robin arbiter that shares one 8-way one-hot select resource among N requesters.
- Outputs a registered one-hot grant vector plus its binary index, so the grant can drive a 3-to-8 style decoded select directly.
- Sits in front of the shared decoder/datapath; each requester holds its grant until it signals done or drops its request.

Parameters:
- N, 8: number of requesters; must be a power of 2, 2..8.
- IDXW, 3: grant index width; must equal log2(N).
- MAX_HOLD, 16: maximum consecutive grant cycles. Used only when the optional feature is enabled; must be at least 2.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  arbitration enable; when low, no new grant is issued.
- req  input  N  request per requester; level-sensitive.
- done  input  N  per-requester release pulse; only done[gnt_idx] is honoured.
- gnt  output  N  one-hot grant, registered.
- gnt_idx  output  IDXW  binary index of the granted requester; valid when gnt_valid=1.
- gnt_valid  output  1  high while any grant is held.
- timeout  output  1  one-cycle pulse when a grant is force-revoked.

Behaviour:
- Reset (rst=1 at a clock edge):
  - gnt=0, gnt_idx=0, gnt_valid=0, timeout=0.
  - Round-robin pointer ptr=0; state goes to IDLE.
  - Reset overrides everything, including an active grant. No release or timeout pulse is produced by a reset.
- States: IDLE, GRANT.
- IDLE:
  - If en=1 and req is nonzero, select the first set bit scanning upward from ptr with wrap-around (ptr, ptr+1, ..., N-1, 0, ..., ptr-1).
  - On the next edge: gnt is the one-hot of the selected index, gnt_idx is that index, gnt_valid=1, ptr=(index+1) mod N, state goes to GRANT.
  - Latency from req rising in IDLE to gnt: 1 cycle.
  - If en=0 or req=0: outputs stay 0 and ptr is unchanged.
- GRANT:
  - Outputs are held constant.
  - Release condition: done[gnt_idx]=1 or req[gnt_idx]=0. On the next edge after release: gnt=0, gnt_valid=0, state goes to IDLE.
  - There is always at least one idle (turnaround) cycle between consecutive grants, even to the same requester.
  - Changes to req or done of non-granted requesters are ignored.
  - en=0 does not revoke an active grant; it only blocks the next grant.
- Simultaneous events:
  - A release and a new request in the same cycle: the new request is arbitrated in the following IDLE cycle.
  - done together with req=0 counts as a single release.
- Fairness: with all requesters continuously requesting, grants cycle 0,1,...,N-1,0 in order.
- gnt_idx holds its last value while gnt_valid=0.
- Only one bit of gnt may ever be high. The all-zero pattern is legal only while gnt_valid=0.
- The block does not decode the index combinationally. gnt and gnt_idx are registered together and are always consistent.

Optional Feature:
- Macro: RR_GRANT_TIMEOUT_EN.
- Defined:
  - A hold counter clears on entry to GRANT and increments every GRANT cycle.
  - If MAX_HOLD cycles pass with no release, force a release on the next edge, identical to a normal release.
  - timeout=1 for exactly that one cycle, coincident with gnt_valid falling.
  - ptr has already advanced, so the offender loses priority.
- Undefined:
  - No counter is built; a grant is held indefinitely.
  - timeout is tied to 0.

Test Plan:
- Reset mid-grant: req=8'h04, grant held, assert rst for 1 cycle -> next cycle gnt=0, gnt_valid=0, timeout=0; then req=8'h01 -> gnt=8'h01 and gnt_idx=0 after 1 cycle (ptr back at 0).
- Round-robin: req=8'hFF held, done[gnt_idx] pulsed 1 cycle after each grant -> gnt_idx sequence 0,1,2,...,7,0, each grant separated by exactly one cycle with gnt_valid=0.
- Wrap-around: after a grant to 6 (ptr=7), req=8'h05 -> next grant is idx 0, then idx 2.
- Release by drop: grant to 3, deassert req[3] -> gnt=0 next edge; done[5] pulses during the grant have no effect.
- Enable gating: en=0, req=8'h10 for 5 cycles -> gnt stays 0; set en=1 -> gnt=8'h10 one cycle later. Clearing en during a grant keeps the grant held.
- Timeout (with RR_GRANT_TIMEOUT_EN, MAX_HOLD=16): req=8'h02 held, no done -> gnt_valid drops after 16 grant cycles with timeout=1 for 1 cycle; without the macro, the grant is held 100+ cycles and timeout stays 0.
